// File: rtl/addsub_arbiter_if.sv
// Handshake and operand bundle between the issue logic, the arbiter,
// the shared addsub32 unit and the response consumer.
interface addsub_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_sub;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_sub;
  logic [31:0] au_a;
  logic [31:0] au_b;
  logic        au_sub;
  logic [31:0] au_ans;
  logic        au_cout;
  logic        au_v;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_ans;
  logic        rsp_cout;
  logic        rsp_v;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sub,
    output req1_ready,
    output au_a, au_b, au_sub,
    input  au_ans, au_cout, au_v,
    output rsp_valid, rsp_id, rsp_ans, rsp_cout, rsp_v,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sub,
    input  req1_ready,
    input  au_a, au_b, au_sub,
    output au_ans, au_cout, au_v,
    input  rsp_valid, rsp_id, rsp_ans, rsp_cout, rsp_v,
    output rsp_ready
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin scheduler sharing one external addsub32 between two requesters.
// Optional ADDSUB_ARB_SAT_EN: saturate rsp_ans on signed overflow.
module addsub_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          RR_INIT       = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  addsub_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        rr_q;
  logic [31:0] a_q, b_q;
  logic        sub_q, id_q;
  logic        rv_q, rid_q, rc_q, rov_q;
  logic [31:0] rans_q;

  logic        gnt, idle, rdy0, rdy1;
  logic        accept, done, drain;
  logic [31:0] cap_ans;

  always_comb begin
    gnt    = (bus.req0_valid & bus.req1_valid) ? rr_q
                                                : bus.req1_valid;
    idle   = rst_n & (state_q == IDLE);
    rdy0   = idle & bus.req0_valid & ~gnt;
    rdy1   = idle & bus.req1_valid & gnt;
    accept = rdy0 | rdy1;
    done   = (state_q == WAIT) & (cnt_q == LAST);
    drain  = (state_q == RESP) & rv_q & bus.rsp_ready;
  end

  always_comb begin
`ifdef ADDSUB_ARB_SAT_EN
    cap_ans = bus.au_ans;
    unique case (1'b1)
      bus.au_v & bus.au_ans[31]:  cap_ans = 32'h7FFF_FFFF;
      bus.au_v & ~bus.au_ans[31]: cap_ans = 32'h8000_0000;
      default:                    cap_ans = bus.au_ans;
    endcase
`else
    cap_ans = bus.au_ans;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (done)   state_d = RESP;
      RESP:    if (drain)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rr_q   <= RR_INIT;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      id_q   <= 1'b0;
      rv_q   <= 1'b0;
      rid_q  <= 1'b0;
      rans_q <= '0;
      rc_q   <= 1'b0;
      rov_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= gnt ? bus.req1_a : bus.req0_a;
        b_q   <= gnt ? bus.req1_b : bus.req0_b;
        sub_q <= gnt ? bus.req1_sub : bus.req0_sub;
        id_q  <= gnt;
        rr_q  <= ~gnt;
        cnt_q <= '0;
      end
      if (state_q == WAIT) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (done) begin
        rv_q   <= 1'b1;
        rid_q  <= id_q;
        rans_q <= cap_ans;
        rc_q   <= bus.au_cout;
        rov_q  <= bus.au_v;
      end
      if (drain) begin
        rv_q <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.au_a       = a_q;
  assign bus.au_b       = b_q;
  assign bus.au_sub     = sub_q;
  assign bus.rsp_valid  = rv_q;
  assign bus.rsp_id     = rid_q;
  assign bus.rsp_ans    = rans_q;
  assign bus.rsp_cout   = rc_q;
  assign bus.rsp_v      = rov_q;

endmodule
